// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one single-ported memory between the CPU fetch
// port and the data port. Accesses are serialised with the data port taking
// priority. The CPU is stalled through `en` until every access requested by
// the current instruction has completed.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2     // read latency, 1..15
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    // memory side
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // CPU advance enable
    output logic              en
);

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr
    } state_e;

    localparam logic [3:0] LAT_INIT = MEM_LAT[3:0];

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              gnt_data_q, gnt_data_d;   // 1: access in flight belongs to data port
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              mem_cs_q, mem_cs_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic if_pend;
    logic d_pend;

    // A port still needs service when it requests, has not yet been served for
    // this instruction, and is not being acknowledged right now.
    assign if_pend = if_req & ~if_done_q & ~if_ack_q;
    assign d_pend  = d_req & ~d_done_q & ~d_ack_q;

    // The CPU may advance once every requesting port is done or acking now.
    assign en = ~reset
              & (~if_req | if_done_q | if_ack_q)
              & (~d_req  | d_done_q  | d_ack_q);

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Next-state logic: arbitration, access sequencing and done tracking.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_data_d  = gnt_data_q;
        if_done_d   = if_done_q;
        d_done_d    = d_done_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        mem_cs_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        // Clearing on en wins over setting on ack: an ack in the en cycle
        // completes the instruction, so nothing must carry over.
        if (if_ack_q) begin
            if_done_d = 1'b1;
        end
        if (d_ack_q) begin
            d_done_d = 1'b1;
        end
        if (en) begin
            if_done_d = 1'b0;
            d_done_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // Data access belongs to the older instruction, so it goes first.
                if (d_pend) begin
                    state_d     = d_we ? StWr : StRd;
                    gnt_data_d  = 1'b1;
                    cnt_d       = LAT_INIT;
                    mem_cs_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (if_pend) begin
                    state_d     = StRd;
                    gnt_data_d  = 1'b0;
                    cnt_d       = LAT_INIT;
                    mem_cs_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                end
            end
            StRd: begin
                // Counter hits zero in the cycle where memory data is valid.
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                    if (gnt_data_q) begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWr: begin
                state_d = StIdle;
                d_ack_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            gnt_data_q  <= 1'b0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_data_q  <= gnt_data_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUTs present outputs.
module tb_mem_port_arbiter;

    localparam int KCs  = 0;
    localparam int KIf  = 1;
    localparam int KD   = 2;
    localparam int KEn  = 3;
    localparam int KCs1 = 4;
    localparam int KIf1 = 5;
    localparam int KEn1 = 6;

    typedef struct {
        int          cyc;
        logic [95:0] data;
    } exp_t;

    exp_t exp_q[7][$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic        clk = 1'b0;
    logic        reset;
    // MEM_LAT = 2 instance
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, d_ack, mem_cs, mem_we, en;
    // MEM_LAT = 1 instance
    logic        l1_if_req;
    logic [31:0] l1_if_addr;
    logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
    logic        l1_if_ack, l1_d_ack, l1_mem_cs, l1_mem_we, l1_en;

    // Memory model state: data is presented only in the cycle it is due.
    logic [31:0] rd_addr0 = 32'h0;
    int          rd_ready0 = -1;
    logic [31:0] rd_addr1 = 32'h0;
    int          rd_ready1 = -1;

    function automatic logic [31:0] mem_value(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h3C1D_1000;
            32'h0000_0004: return 32'h2008_0005;
            32'h0000_0008: return 32'h8C09_0100;
            32'h0000_0100: return 32'h0000_ABCD;
            32'h0000_0104: return 32'h1234_5678;
            default:       return 32'hDEAD_DEAD;
        endcase
    endfunction

    function automatic logic [95:0] cs_word(input logic we, input logic [31:0] a,
                                            input logic [31:0] wd);
        return {31'b0, we, a, we ? wd : 32'h0};
    endfunction

    assign mem_rdata    = (cyc == rd_ready0) ? mem_value(rd_addr0) : 32'hBAD0_BAD0;
    assign l1_mem_rdata = (cyc == rd_ready1) ? mem_value(rd_addr1) : 32'hBAD0_BAD0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .en        (en)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
        .clk       (clk),
        .reset     (reset),
        .if_req    (l1_if_req),
        .if_addr   (l1_if_addr),
        .if_rdata  (l1_if_rdata),
        .if_ack    (l1_if_ack),
        .d_req     (1'b0),
        .d_we      (1'b0),
        .d_addr    (32'h0),
        .d_wdata   (32'h0),
        .d_rdata   (l1_d_rdata),
        .d_ack     (l1_d_ack),
        .mem_cs    (l1_mem_cs),
        .mem_we    (l1_mem_we),
        .mem_addr  (l1_mem_addr),
        .mem_wdata (l1_mem_wdata),
        .mem_rdata (l1_mem_rdata),
        .en        (l1_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int k, input int c, input logic [95:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        exp_q[k].push_back(e);
    endtask

    task automatic push_en(input int k, input int from, input int to, input logic v);
        for (int c = from; c <= to; c++) push(k, c, {95'b0, v});
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Strobe outputs: pop on every pulse; an overdue entry means a missed pulse.
    task automatic observe(input int k, input logic strobe, input logic [95:0] act,
                           input string name);
        exp_t e;
        if (strobe) begin
            checks++;
            if (exp_q[k].size() == 0) begin
                errors++;
                $display("FAIL %s: unexpected pulse in cycle %0d, data %h", name, cyc, act);
            end else begin
                e = exp_q[k].pop_front();
                if (e.cyc != cyc || e.data !== act) begin
                    errors++;
                    $display("FAIL %s: got cycle %0d data %h, expected cycle %0d data %h",
                             name, cyc, act, e.cyc, e.data);
                end
            end
        end else if (exp_q[k].size() != 0 && exp_q[k][0].cyc < cyc) begin
            e = exp_q[k].pop_front();
            checks++;
            errors++;
            $display("FAIL %s: no pulse, expected cycle %0d data %h", name, e.cyc, e.data);
        end
    endtask

    // Level outputs: compare only in the cycles the stimulus asked about.
    task automatic observe_level(input int k, input logic act, input string name);
        exp_t e;
        if (exp_q[k].size() != 0 && exp_q[k][0].cyc <= cyc) begin
            e = exp_q[k].pop_front();
            checks++;
            if (e.cyc != cyc || e.data[0] !== act) begin
                errors++;
                $display("FAIL %s: cycle %0d got %b, expected cycle %0d value %b",
                         name, cyc, act, e.cyc, e.data[0]);
            end
        end
    endtask

    // Monitor and memory models.
    always @(negedge clk) begin
        observe(KCs, mem_cs, cs_word(mem_we, mem_addr, mem_wdata), "mem_cs");
        observe(KIf, if_ack, {64'b0, if_rdata}, "if_ack");
        observe(KD, d_ack, {64'b0, d_rdata}, "d_ack");
        observe_level(KEn, en, "en");
        observe(KCs1, l1_mem_cs, cs_word(l1_mem_we, l1_mem_addr, l1_mem_wdata), "lat1_mem_cs");
        observe(KIf1, l1_if_ack, {64'b0, l1_if_rdata}, "lat1_if_ack");
        observe_level(KEn1, l1_en, "lat1_en");
        if (mem_cs && !mem_we) begin
            rd_addr0  <= mem_addr;
            rd_ready0 <= cyc + 2;
        end
        if (l1_mem_cs && !l1_mem_we) begin
            rd_addr1  <= l1_mem_addr;
            rd_ready1 <= cyc + 1;
        end
    end

    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int b;
        reset      = 1'b1;
        if_req     = 1'b0;
        if_addr    = 32'h0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = 32'h0;
        d_wdata    = 32'h0;
        l1_if_req  = 1'b0;
        l1_if_addr = 32'h0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_en", {95'b0, en}, 96'h0);
        chk("rst_strobes", {93'b0, if_ack, d_ack, mem_cs}, 96'h0);
        chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 96'h0);
        chk("rst_rdata", {32'h0, if_rdata, d_rdata}, 96'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_en", {95'b0, en}, 96'h1);
        chk("idle_cs", {95'b0, mem_cs}, 96'h0);
        @(posedge clk);
        #1;

        // Fetch only
        b = cyc;
        if_req  = 1'b1;
        if_addr = 32'h4;
        push(KCs, b + 1, cs_word(1'b0, 32'h4, 32'h0));
        push(KIf, b + 4, {64'b0, 32'h2008_0005});
        push_en(KEn, b, b + 3, 1'b0);
        push_en(KEn, b + 4, b + 5, 1'b1);
        goto_cyc(b + 5);
        if_req = 1'b0;
        goto_cyc(b + 7);

        // Fetch plus data read: data first
        b = cyc;
        if_req  = 1'b1;
        if_addr = 32'h8;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h100;
        push(KCs, b + 1, cs_word(1'b0, 32'h100, 32'h0));
        push(KD, b + 4, {64'b0, 32'h0000_ABCD});
        push(KCs, b + 5, cs_word(1'b0, 32'h8, 32'h0));
        push(KIf, b + 8, {64'b0, 32'h8C09_0100});
        push_en(KEn, b, b + 7, 1'b0);
        push_en(KEn, b + 8, b + 9, 1'b1);
        goto_cyc(b + 9);
        if_req = 1'b0;
        d_req  = 1'b0;
        goto_cyc(b + 11);

        // Data write; d_rdata keeps the previous load value
        b = cyc;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h200;
        d_wdata = 32'hDEAD_BEEF;
        push(KCs, b + 1, cs_word(1'b1, 32'h200, 32'hDEAD_BEEF));
        push(KD, b + 2, {64'b0, 32'h0000_ABCD});
        push_en(KEn, b, b + 1, 1'b0);
        push_en(KEn, b + 2, b + 2, 1'b1);
        goto_cyc(b + 3);
        d_req = 1'b0;
        d_we  = 1'b0;
        goto_cyc(b + 5);

        // Reset during a fetch read
        b = cyc;
        if_req  = 1'b1;
        if_addr = 32'h4;
        push(KCs, b + 1, cs_word(1'b0, 32'h4, 32'h0));
        push_en(KEn, b, b + 2, 1'b0);
        goto_cyc(b + 2);
        reset = 1'b1;
        goto_cyc(b + 3);
        reset = 1'b0;
        push_en(KEn, b + 3, b + 6, 1'b0);
        push_en(KEn, b + 7, b + 7, 1'b1);
        push(KCs, b + 4, cs_word(1'b0, 32'h4, 32'h0));
        push(KIf, b + 7, {64'b0, 32'h2008_0005});
        @(negedge clk);
        chk("post_rst_strobes", {93'b0, if_ack, d_ack, mem_cs}, 96'h0);
        chk("post_rst_mem", {mem_we, mem_addr, mem_wdata}, 96'h0);
        chk("post_rst_rdata", {32'h0, if_rdata, d_rdata}, 96'h0);
        goto_cyc(b + 8);
        if_req = 1'b0;
        goto_cyc(b + 10);

        // Back-to-back instructions with requests held across en
        b = cyc;
        if_req  = 1'b1;
        if_addr = 32'h4;
        d_req   = 1'b1;
        d_addr  = 32'h100;
        push(KCs, b + 1, cs_word(1'b0, 32'h100, 32'h0));
        push(KD, b + 4, {64'b0, 32'h0000_ABCD});
        push(KCs, b + 5, cs_word(1'b0, 32'h4, 32'h0));
        push(KIf, b + 8, {64'b0, 32'h2008_0005});
        push(KCs, b + 10, cs_word(1'b0, 32'h104, 32'h0));
        push(KD, b + 13, {64'b0, 32'h1234_5678});
        push(KCs, b + 14, cs_word(1'b0, 32'h8, 32'h0));
        push(KIf, b + 17, {64'b0, 32'h8C09_0100});
        push_en(KEn, b, b + 7, 1'b0);
        push_en(KEn, b + 8, b + 8, 1'b1);
        push_en(KEn, b + 9, b + 16, 1'b0);
        push_en(KEn, b + 17, b + 18, 1'b1);
        goto_cyc(b + 9);
        if_addr = 32'h8;
        d_addr  = 32'h104;
        goto_cyc(b + 18);
        if_req = 1'b0;
        d_req  = 1'b0;
        goto_cyc(b + 20);

        // Flush: request dropped mid-access, ack still arrives, no re-grant
        b = cyc;
        if_req  = 1'b1;
        if_addr = 32'h0;
        push(KCs, b + 1, cs_word(1'b0, 32'h0, 32'h0));
        push_en(KEn, b, b + 1, 1'b0);
        goto_cyc(b + 2);
        if_req = 1'b0;
        push_en(KEn, b + 2, b + 4, 1'b1);
        push(KIf, b + 4, {64'b0, 32'h3C1D_1000});
        goto_cyc(b + 9);

        // MEM_LAT = 1 instance
        b = cyc;
        l1_if_req  = 1'b1;
        l1_if_addr = 32'h0;
        push(KCs1, b + 1, cs_word(1'b0, 32'h0, 32'h0));
        push(KIf1, b + 3, {64'b0, 32'h3C1D_1000});
        push_en(KEn1, b, b + 2, 1'b0);
        push_en(KEn1, b + 3, b + 3, 1'b1);
        goto_cyc(b + 4);
        l1_if_req = 1'b0;
        goto_cyc(b + 8);

        // Anything still queued was never presented by the DUT.
        for (int k = 0; k < 7; k++) begin
            while (exp_q[k].size() != 0) begin
                exp_t e;
                e = exp_q[k].pop_front();
                checks++;
                errors++;
                $display("FAIL leftover_kind%0d: never seen, expected cycle %0d data %h",
                         k, e.cyc, e.data);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
